// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Purpose:
//   MEM pipeline stage of a simple in-order core. Turns a load/store held
//   in the EX/MEM slot into a single data-memory request, waits for the
//   one-cycle acknowledge (bounded by TIMEOUT_CYC), extracts and extends
//   load data, and writes the result into the MEM/WB registers. Any other
//   instruction passes straight through with one cycle of latency.
//
// Parameter:
//   TIMEOUT_CYC   ACCESS cycles to wait for dmemAck before aborting (1..255)
//
// Optional feature (compile-time macro):
//   MEM_MISALIGN_TRAP_EN  defined   : misaligned half/word accesses issue no
//                                     request and pulse misalignErr.
//                         undefined : misaligned addresses are silently
//                                     aligned; misalignErr stays 0.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   validMem                   EX/MEM slot holds a real instruction
//   aluResultMem[31:0]         effective address / ALU result
//   busBMem[31:0]              store data
//   memCtrlMem[4:0]            [0] read, [1] write, [3:2] size, [4] sign-ext
//   rWMem[4:0], wrCtrlMem[1:0] destination / writeback select (pass-through)
//   stall                      combinational upstream freeze
//   dmemReq/We/Addr/Be/WData   registered data-memory request
//   dmemAck, dmemRData         memory completion and read data
//   validWb, aluResultWb, memDataWb, rWWb, wrCtrlWb   MEM/WB registers
//   busErr                     one-cycle pulse on timeout
//   misalignErr                one-cycle pulse on trapped misalignment
//   dbg_state                  current FSM state (0 IDLE, 1 ACCESS)
//
// Memory handshake: dmemReq and its address/enable/data are raised on the
// edge that enters ACCESS and held stable until the cycle in which dmemAck
// is high; that cycle completes the transfer and the next edge drops
// dmemReq. dmemAck outside ACCESS is ignored. At most one request is in
// flight and each memop takes at least two cycles.
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        validMem,
    input  logic [31:0] aluResultMem,
    input  logic [31:0] busBMem,
    input  logic [4:0]  memCtrlMem,
    input  logic [4:0]  rWMem,
    input  logic [1:0]  wrCtrlMem,
    output logic        stall,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [3:0]  dmemBe,
    output logic [31:0] dmemWData,
    input  logic        dmemAck,
    input  logic [31:0] dmemRData,
    output logic        validWb,
    output logic [31:0] aluResultWb,
    output logic [31:0] memDataWb,
    output logic [4:0]  rWWb,
    output logic [1:0]  wrCtrlWb,
    output logic        busErr,
    output logic        misalignErr,
    output logic        dbg_state
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // Counter value on the last permitted wait cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic        valid_wb_q, valid_wb_d;
    logic [31:0] alu_result_wb_q, alu_result_wb_d;
    logic [31:0] mem_data_wb_q, mem_data_wb_d;
    logic [4:0]  rw_wb_q, rw_wb_d;
    logic [1:0]  wr_ctrl_wb_q, wr_ctrl_wb_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_err_q, misalign_err_d;

    logic        stall_c;
    logic        memop;
    logic        is_write;
    logic [1:0]  acc_size;
    logic        sign_ext;
    logic        trap_hit;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    // ------------------------------------------------------------------
    // Decode. Inputs are frozen by stall, so they stay valid for the
    // whole access and are used directly when the ack arrives.
    // ------------------------------------------------------------------
    assign memop    = validMem & (memCtrlMem[0] | memCtrlMem[1]);
    assign is_write = memCtrlMem[1];          // write wins if both set
    assign acc_size = memCtrlMem[3:2];
    assign sign_ext = memCtrlMem[4];

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_hit = ((acc_size == 2'b01) & aluResultMem[0]) |
                      (acc_size[1] & (aluResultMem[1:0] != 2'b00));
`else
    assign trap_hit = 1'b0;
`endif

    // Byte enables and lane-replicated store data. Half accesses use only
    // addr[1], which silently aligns a misaligned half when not trapping.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = busBMem;
        case (acc_size)
            2'b00: begin
                req_be    = 4'b0001 << aluResultMem[1:0];
                req_wdata = {4{busBMem[7:0]}};
            end
            2'b01: begin
                req_be    = aluResultMem[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{busBMem[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = busBMem;
            end
        endcase
    end

    // Load lane selection and extension.
    always_comb begin
        ld_byte = dmemRData[7:0];
        case (aluResultMem[1:0])
            2'b00:   ld_byte = dmemRData[7:0];
            2'b01:   ld_byte = dmemRData[15:8];
            2'b10:   ld_byte = dmemRData[23:16];
            default: ld_byte = dmemRData[31:24];
        endcase
        ld_half = aluResultMem[1] ? dmemRData[31:16] : dmemRData[15:0];
        case (acc_size)
            2'b00:   load_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{sign_ext & ld_half[15]}}, ld_half};
            default: load_data = dmemRData;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic. WB payload fields follow the inputs every cycle;
    // validWb qualifies them.
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_be_d       = dmem_be_q;
        dmem_wdata_d    = dmem_wdata_q;
        valid_wb_d      = 1'b0;
        alu_result_wb_d = aluResultMem;
        mem_data_wb_d   = 32'd0;
        rw_wb_d         = rWMem;
        wr_ctrl_wb_d    = wrCtrlMem;
        bus_err_d       = 1'b0;
        misalign_err_d  = 1'b0;
        stall_c         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (memop && trap_hit) begin
                    misalign_err_d = 1'b1;
                end else if (memop) begin
                    stall_c      = 1'b1;
                    state_d      = S_ACCESS;
                    cnt_d        = 8'd0;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = is_write;
                    dmem_addr_d  = {aluResultMem[31:2], 2'b00};
                    dmem_be_d    = req_be;
                    dmem_wdata_d = req_wdata;
                end else begin
                    valid_wb_d = validMem;
                end
            end
            S_ACCESS: begin
                // Ack is checked first so an ack on the timeout cycle wins.
                if (dmemAck || cnt_q == CNT_LAST) begin
                    state_d      = S_IDLE;
                    dmem_req_d   = 1'b0;
                    dmem_we_d    = 1'b0;
                    dmem_addr_d  = 32'd0;
                    dmem_be_d    = 4'd0;
                    dmem_wdata_d = 32'd0;
                    if (dmemAck) begin
                        valid_wb_d    = 1'b1;
                        mem_data_wb_d = is_write ? 32'd0 : load_data;
                    end else begin
                        // Stall drops here so upstream discards the op.
                        bus_err_d = 1'b1;
                    end
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= 8'd0;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= 32'd0;
            dmem_be_q       <= 4'd0;
            dmem_wdata_q    <= 32'd0;
            valid_wb_q      <= 1'b0;
            alu_result_wb_q <= 32'd0;
            mem_data_wb_q   <= 32'd0;
            rw_wb_q         <= 5'd0;
            wr_ctrl_wb_q    <= 2'd0;
            bus_err_q       <= 1'b0;
            misalign_err_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_be_q       <= dmem_be_d;
            dmem_wdata_q    <= dmem_wdata_d;
            valid_wb_q      <= valid_wb_d;
            alu_result_wb_q <= alu_result_wb_d;
            mem_data_wb_q   <= mem_data_wb_d;
            rw_wb_q         <= rw_wb_d;
            wr_ctrl_wb_q    <= wr_ctrl_wb_d;
            bus_err_q       <= bus_err_d;
            misalign_err_q  <= misalign_err_d;
        end
    end

    // Stall is forced low while reset is asserted.
    assign stall       = rst_n & stall_c;
    assign dmemReq     = dmem_req_q;
    assign dmemWe      = dmem_we_q;
    assign dmemAddr    = dmem_addr_q;
    assign dmemBe      = dmem_be_q;
    assign dmemWData   = dmem_wdata_q;
    assign validWb     = valid_wb_q;
    assign aluResultWb = alu_result_wb_q;
    assign memDataWb   = mem_data_wb_q;
    assign rWWb        = rw_wb_q;
    assign wrCtrlWb    = wr_ctrl_wb_q;
    assign busErr      = bus_err_q;
    assign misalignErr = misalign_err_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, max ACCESS cycles awaiting dmemAck before abort (1..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 validMem  in  1  EX/MEM slot holds a real instruction (0 = bubble).
REQ-005 aluResultMem  in  32  effective address / ALU result.
REQ-006 busBMem  in  32  store data.
REQ-007 memCtrlMem  in  5  [0]=read, [1]=write, [3:2]=size (00 byte, 01 half, 10 word, 11 reserved = word), [4]=sign-extend load.
REQ-008 rWMem  in  5  destination register; wrCtrlMem  in  2  writeback select, passed through.
REQ-009 stall  out  1  combinational; drives EX/MEM write enable low and freezes upstream stages.
REQ-010 dmemReq  out  1; dmemWe  out  1; dmemAddr  out  32 (bits [1:0]=0); dmemBe  out  4; dmemWData  out  32; all registered.
REQ-011 dmemAck  in  1  one-cycle completion; dmemRData  in  32  valid when dmemAck=1.
REQ-012 validWb  out  1; aluResultWb  out  32; memDataWb  out  32; rWWb  out  5; wrCtrlWb  out  2; all registered, to MEM/WB.
REQ-013 busErr  out  1  registered one-cycle pulse on timeout; misalignErr  out  1  registered one-cycle pulse (see Configuration).

Function
REQ-014 FSM states: IDLE, ACCESS; memop = validMem & (read | write); write has priority when both bits set.
REQ-015 IDLE, no memop: each edge copies inputs to WB outputs, validWb=validMem, memDataWb=0; latency 1 cycle; stall=0.
REQ-016 IDLE, memop: stall=1 combinationally; next edge enters ACCESS, asserts dmemReq, loads dmemAddr/dmemBe/dmemWData/dmemWe, clears timeout counter, sets validWb=0.
REQ-017 ACCESS: stall = ~dmemAck; request signals held stable until ack; counter increments each cycle without ack.
REQ-018 ACCESS with dmemAck=1: next edge returns to IDLE, drops dmemReq, writes WB outputs with validWb=1; memDataWb = extended load data for reads, 0 for writes.
REQ-019 Byte: dmemBe=0001<<addr[1:0], wdata = byte replicated x4; half: dmemBe=0011 (addr[1]=0) or 1100, wdata = half replicated x2; word: 1111.
REQ-020 Load extraction selects lane by addr[1:0]; zero-extend unless memCtrlMem[4]=1, then sign-extend from bit 7/15.
REQ-021 Counter reaching TIMEOUT_CYC without ack: next edge to IDLE, dmemReq=0, busErr=1 for one cycle, validWb=0, stall released.
REQ-022 dmemAck in IDLE ignored; ack on the timeout cycle is honoured (ack wins).
REQ-023 Inputs are stable while stall=1 (guaranteed by upstream freeze); block samples them only in IDLE.
REQ-024 Back-to-back memops: every memop costs at least 2 cycles (IDLE decision + ACCESS); no pipelined requests.

Reset
REQ-025 rst_n=0 forces IDLE, all outputs 0, counter 0 immediately, including mid-ACCESS (request abandoned, no error pulse).
REQ-026 First edge after release behaves as IDLE.

Configuration
REQ-027 Macro MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no request, stall=0, next edge pulses misalignErr=1, validWb=0.
REQ-028 Macro undefined: misaligned addresses silently aligned (half clears addr[0], word clears addr[1:0]); misalignErr tied 0.

Verification
REQ-029 Word load addr 0x100, ack after 3 ACCESS cycles, rdata 0xDEADBEEF -> stall high 4 cycles, memDataWb=0xDEADBEEF, validWb=1 once.
REQ-030 Signed byte load addr 0x103, rdata 0x80xxxxxx -> memDataWb=0xFFFFFF80; unsigned same -> 0x00000080.
REQ-031 Half store addr 0x202, busB 0x1234ABCD -> dmemBe=1100, dmemWData=0xABCDABCD, dmemWe=1, memDataWb=0.
REQ-032 Read with no ack, TIMEOUT_CYC=4 -> busErr pulse after 4 ACCESS cycles, dmemReq low, stall low next cycle.
REQ-033 rst_n low during ACCESS -> dmemReq, stall, validWb 0 asynchronously; next op after release proceeds normally.
REQ-034 Word load addr 0x101: with MEM_MISALIGN_TRAP_EN -> misalignErr pulse, no dmemReq; without -> dmemAddr=0x100.
